// File: rtl/rns_113_127_128_pkg.sv
// Shared constants and helpers for the (113,127,128) residue-to-binary converter.
package rns_113_127_128_pkg;
  localparam int RES_W      = 7;
  localparam int X_W        = 21;
  localparam int MOD_A      = 113;
  localparam int MOD_B      = 127;
  localparam int MOD_C      = 128;
  localparam int INV128_113 = 98;
  localparam int INV127_113 = 105;
  localparam int W2         = 128;
  localparam int W3         = 16256;
  localparam int M          = 1836928;
  // 2^7 mod 113, used to fold high bits back into the low 7
  localparam int FOLD_113   = 15;

  typedef struct packed {
    logic [RES_W-1:0] r113;
    logic [RES_W-1:0] r127;
    logic [RES_W-1:0] r128;
  } rns_triple_t;

  // Single conditional correction: inputs are at most one modulus past range.
  function automatic logic [RES_W-1:0] red1(input logic [RES_W-1:0] a, input logic [7:0] m);
    logic [7:0] d;
    d = {1'b0, a};
    if (d >= m) d = d - m;
    return d[RES_W-1:0];
  endfunction

  // (a - b) mod m; the extra subtract only matters for unchecked out-of-range a.
  function automatic logic [RES_W-1:0] mod_sub(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b,
                                               input logic [7:0] m);
    logic [7:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[7])        d = d + m;
    else if (d >= m) d = d - m;
    return d[RES_W-1:0];
  endfunction
endpackage

// File: rtl/rns_113_127_128_to_bin_mod113_mulc.sv
// Combinational a*C mod 113 using two 2^7 == 15 folds and a small final correction.
module mod113_mulc
  import rns_113_127_128_pkg::*;
#(
  parameter logic [RES_W-1:0] C = 7'd1
) (
  input  logic [RES_W-1:0] a,
  output logic [RES_W-1:0] y
);
  logic [13:0] p;
  logic [10:0] f1;
  logic [8:0]  f2;
  logic [8:0]  r;

  assign p  = 14'(a) * 14'(C);
  // p <= 16129 -> f1 <= 2017 -> f2 <= 352
  assign f1 = 11'(p[13:7]) * 11'(FOLD_113) + 11'(p[6:0]);
  assign f2 = 9'(f1[10:7]) * 9'(FOLD_113) + 9'(f1[6:0]);
  assign r  = (f2 >= 9'd226) ? f2 - 9'd226 : f2;
  assign y  = (r >= 9'd113) ? 7'(r - 9'd113) : r[RES_W-1:0];
endmodule

// File: rtl/rns_113_127_128_to_bin.sv
// Mixed-radix residue-to-binary converter, one triple in flight, 4-cycle latency.
module rns_113_127_128_to_bin
  import rns_113_127_128_pkg::*;
#(
  parameter int CHECK_RANGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] R_113,
  input  logic [RES_W-1:0] R_127,
  input  logic [RES_W-1:0] R_128,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   X,
  output logic             err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A2   = 3'd1;
  localparam logic [2:0] A3   = 3'd2;
  localparam logic [2:0] SUM  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  rns_triple_t      res;
  logic [RES_W-1:0] a2, t, a3;
  logic             rng_err;

  logic [RES_W-1:0] a2_next, t_diff, t_next, a3_diff, a3_next;
  logic [X_W-1:0]   x_sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // a1 is R_128 itself; its residues mod 127 and 113 need one correction each
  assign a2_next = mod_sub(res.r127, red1(res.r128, 8'(MOD_B)), 8'(MOD_B));
  assign t_diff  = mod_sub(res.r113, red1(res.r128, 8'(MOD_A)), 8'(MOD_A));
  assign a3_diff = mod_sub(t, red1(a2, 8'(MOD_A)), 8'(MOD_A));

  mod113_mulc #(.C(7'(INV128_113))) u_mul_t  (.a(t_diff),  .y(t_next));
  mod113_mulc #(.C(7'(INV127_113))) u_mul_a3 (.a(a3_diff), .y(a3_next));

  assign x_sum = X_W'(res.r128) + X_W'(a2) * X_W'(W2) + X_W'(a3) * X_W'(W3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      res     <= '0;
      a2      <= '0;
      t       <= '0;
      a3      <= '0;
      rng_err <= 1'b0;
      X       <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          res.r113 <= R_113;
          res.r127 <= R_127;
          res.r128 <= R_128;
          state    <= A2;
        end
        A2: begin
          a2      <= a2_next;
          t       <= t_next;
          rng_err <= (CHECK_RANGE != 0) &&
                     ((res.r113 > 7'(MOD_A - 1)) || (res.r127 > 7'(MOD_B - 1)));
          state   <= A3;
        end
        A3: begin
          a3    <= a3_next;
          state <= SUM;
        end
        SUM: begin
          X     <= rng_err ? '0 : x_sum;
          err   <= rng_err;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_113_127_128_to_bin.sv
// Self-checking bench: directed corner cases plus random X values checked by CRT residues.
module tb_rns_113_127_128_to_bin;
  localparam int MV = 113 * 127 * 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  R_113 = '0, R_127 = '0, R_128 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] X;
  logic        err;

  int checks = 0;
  int errors = 0;

  rns_113_127_128_to_bin #(.CHECK_RANGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .R_113(R_113), .R_127(R_127), .R_128(R_128),
    .out_valid(out_valid), .out_ready(out_ready), .X(X), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one triple; returns the result and the cycle count from accept edge to out_valid.
  task automatic send(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                      output logic [20:0] x, output logic e, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    R_113 = a; R_127 = b; R_128 = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    x = X; e = err;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || X !== 21'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b X=%0d err=%b, want 0 0 0", out_valid, X, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [20:0] x; logic e; int lat;
    out_ready = 1'b1;
    send(7'd63, 7'd2, 7'd64, x, e, lat);
    checks++;
    if (x !== 21'd1000000 || e !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL directed_1e6: X=%0d err=%b lat=%0d, want 1000000 0 4", x, e, lat);
    end
    @(posedge clk); #1;
    send(7'd0, 7'd0, 7'd0, x, e, lat);
    checks++;
    if (x !== 21'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL directed_zero: X=%0d err=%b, want 0 0", x, e);
    end
    @(posedge clk); #1;
    send(7'd112, 7'd126, 7'd127, x, e, lat);
    checks++;
    if (x !== 21'(MV - 1) || e !== 1'b0) begin
      errors++;
      $display("FAIL directed_max: X=%0d err=%b, want %0d 0", x, e, MV - 1);
    end
    @(posedge clk); #1;
    send(7'd113, 7'd5, 7'd9, x, e, lat);
    checks++;
    if (x !== 21'd0 || e !== 1'b1 || lat !== 4) begin
      errors++;
      $display("FAIL range_r113: X=%0d err=%b lat=%0d, want 0 1 4", x, e, lat);
    end
    @(posedge clk); #1;
    send(7'd4, 7'd127, 7'd9, x, e, lat);
    checks++;
    if (x !== 21'd0 || e !== 1'b1) begin
      errors++;
      $display("FAIL range_r127: X=%0d err=%b, want 0 1", x, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [20:0] x; logic e; int lat;
    out_ready = 1'b1;
    send(7'd10, 7'd20, 7'd30, x, e, lat);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one_cycle_valid: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] x, x0; logic e; int lat, bad;
    out_ready = 1'b0;
    send(7'd63, 7'd2, 7'd64, x0, e, lat);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || X !== 21'd1000000) bad++;
    end
    checks++;
    if (bad != 0 || x0 !== 21'd1000000) begin
      errors++;
      $display("FAIL backpressure_hold: bad_cycles=%0d X=%0d, want 0 1000000", bad, x0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    x = X;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b X=%0d, want 0 1", out_valid, in_ready, x);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b1;
    R_113 = 7'd1; R_127 = 7'd2; R_128 = 7'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (X !== 21'd0 || err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_async_clear: X=%0d err=%b out_valid=%b, want 0 0 0", X, err, out_valid);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_discard: valid_cycles=%0d in_ready=%b, want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_random(input int n);
    logic [20:0] x; logic e; int lat, xv, a, b, c, want_x, want_e;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 7) begin
        a = $urandom_range(113, 127);
        b = $urandom_range(0, 127);
        c = $urandom_range(0, 127);
        if ($urandom_range(0, 1) == 1) begin a = $urandom_range(0, 112); b = 127; end
        want_x = 0; want_e = 1;
      end else begin
        xv = (i < 2) ? (i == 0 ? 1 : MV - 2) : int'($urandom_range(0, MV - 1));
        a = xv % 113; b = xv % 127; c = xv % 128;
        want_x = xv; want_e = 0;
      end
      send(7'(a), 7'(b), 7'(c), x, e, lat);
      checks++;
      if (x !== 21'(want_x) || e !== 1'(want_e) || lat !== 4) begin
        errors++;
        $display("FAIL random[%0d] (%0d,%0d,%0d): X=%0d err=%b lat=%0d, want %0d %0d 4",
                 i, a, b, c, x, e, lat, want_x, want_e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
